// File: rtl/bist_pattern_ctrl.sv
// BIST controller: Galois-LFSR pattern source and MISR response compactor for a
// sequential CUT, with a golden-signature pass/fail verdict.
module bist_pattern_ctrl #(
  parameter int unsigned      IN_W      = 35,
  parameter int unsigned      OUT_W     = 24,
  parameter int unsigned      NPAT      = 1024,
  parameter logic [IN_W-1:0]  LFSR_POLY = 35'h500000000,
  parameter logic [IN_W-1:0]  SEED      = IN_W'(1),
  parameter logic [OUT_W-1:0] MISR_POLY = 24'hE10000,
  parameter logic [OUT_W-1:0] GOLDEN    = '0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [OUT_W-1:0] RESP,
  output logic [IN_W-1:0]  PAT,
  output logic             CUT_EN,
  output logic             CUT_INIT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [OUT_W-1:0] SIG
);

  localparam int unsigned     CNT_W    = $clog2(NPAT + 1);
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IN_W-1:0]  r_pat;
  logic [OUT_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;

  logic             w_adv;
  logic             w_last;
  logic [IN_W-1:0]  w_pat_nxt;
  logic [OUT_W-1:0] w_sig_nxt;

  assign w_adv  = (r_state == S_RUN) && !ABORT;
  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_pat_nxt = (r_pat >> 1) ^ (r_pat[0] ? LFSR_POLY : '0);
    w_sig_nxt = (r_sig << 1) ^ (r_sig[OUT_W-1] ? MISR_POLY : '0) ^ RESP;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START && !ABORT) w_state_nxt = S_INIT;
      S_INIT:  w_state_nxt = ABORT ? S_IDLE : S_RUN;
      S_RUN: begin
        if (ABORT)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (ABORT)      w_state_nxt = S_IDLE;
        else if (START) w_state_nxt = S_INIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_pat   <= SEED_EFF;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_pat <= SEED_EFF;
        r_sig <= '0;
        r_cnt <= '0;
      end else if (w_adv) begin
        r_pat <= w_pat_nxt;
        r_sig <= w_sig_nxt;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      // Verdict is latched from the final signature on the edge entering DONE
      if (w_state_nxt != S_DONE)  r_pass <= 1'b0;
      else if (r_state == S_RUN)  r_pass <= (w_sig_nxt == GOLDEN);
    end
  end

  assign PAT      = r_pat;
  assign SIG      = r_sig;
  assign PASS     = r_pass;
  assign CUT_EN   = (r_state == S_RUN);
  assign CUT_INIT = (r_state == S_INIT);
  assign BUSY     = (r_state == S_INIT) || (r_state == S_RUN);
  assign DONE     = (r_state == S_DONE);

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Directed bench for bist_pattern_ctrl: four small instances share stimulus
// (NPAT=6 LFSR/MISR, NPAT=3 with matching and mismatching golden, NPAT=1).
module tb_bist_pattern_ctrl;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] RESP = 4'h1;

  logic [3:0] patA, sigA, patB, sigB, patC, sigC, patD, sigD;
  logic       enA, initA, busyA, doneA, passA;
  logic       enB, initB, busyB, doneB, passB;
  logic       enC, initC, busyC, doneC, passC;
  logic       enD, initD, busyD, doneD, passD;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  bist_pattern_ctrl #(.IN_W(4), .OUT_W(4), .NPAT(6), .LFSR_POLY(4'hC), .SEED(4'h1),
                      .MISR_POLY(4'h3), .GOLDEN(4'hA)) u_a (
    .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .RESP(RESP), .PAT(patA),
    .CUT_EN(enA), .CUT_INIT(initA), .BUSY(busyA), .DONE(doneA), .PASS(passA), .SIG(sigA));

  bist_pattern_ctrl #(.IN_W(4), .OUT_W(4), .NPAT(3), .LFSR_POLY(4'hC), .SEED(4'h1),
                      .MISR_POLY(4'h3), .GOLDEN(4'h7)) u_b (
    .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .RESP(RESP), .PAT(patB),
    .CUT_EN(enB), .CUT_INIT(initB), .BUSY(busyB), .DONE(doneB), .PASS(passB), .SIG(sigB));

  bist_pattern_ctrl #(.IN_W(4), .OUT_W(4), .NPAT(3), .LFSR_POLY(4'hC), .SEED(4'h1),
                      .MISR_POLY(4'h3), .GOLDEN(4'h6)) u_c (
    .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .RESP(RESP), .PAT(patC),
    .CUT_EN(enC), .CUT_INIT(initC), .BUSY(busyC), .DONE(doneC), .PASS(passC), .SIG(sigC));

  bist_pattern_ctrl #(.IN_W(4), .OUT_W(4), .NPAT(1), .LFSR_POLY(4'hC), .SEED(4'h0),
                      .MISR_POLY(4'h3), .GOLDEN(4'h1)) u_d (
    .CK(CK), .RN(RN), .START(START), .ABORT(ABORT), .RESP(RESP), .PAT(patD),
    .CUT_EN(enD), .CUT_INIT(initD), .BUSY(busyD), .DONE(doneD), .PASS(passD), .SIG(sigD));

  typedef struct {
    logic       st, ab;
    logic [3:0] pA, sA;
    logic       bA, iA, eA, dA, qA;
    logic [3:0] sB;
    logic       iB, dB, qB;
    logic       qC;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_idle_a(input string tag, input logic [3:0] pat, input logic [3:0] sig);
    chk({tag, "_patA"},  patA,  pat);
    chk({tag, "_sigA"},  sigA,  sig);
    chk({tag, "_busyA"}, busyA, 1'b0);
    chk({tag, "_enA"},   enA,   1'b0);
    chk({tag, "_initA"}, initA, 1'b0);
    chk({tag, "_doneA"}, doneA, 1'b0);
    chk({tag, "_passA"}, passA, 1'b0);
  endtask

  initial begin
    //            st ab  pA    sA    bA iA eA dA qA  sB    iB dB qB  qC
    vq.push_back('{1, 0, 4'h1, 4'h0, 1, 1, 0, 0, 0, 4'h0, 1, 0, 0, 0}); // IDLE->INIT
    vq.push_back('{0, 0, 4'h1, 4'h0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0}); // RUN0
    vq.push_back('{0, 0, 4'hC, 4'h1, 1, 0, 1, 0, 0, 4'h1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'h6, 4'h3, 1, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'h3, 4'h7, 1, 0, 1, 0, 0, 4'h7, 0, 1, 1, 0}); // B done
    vq.push_back('{0, 0, 4'hD, 4'hF, 1, 0, 1, 0, 0, 4'h7, 0, 1, 1, 0});
    vq.push_back('{0, 0, 4'hA, 4'hC, 1, 0, 1, 0, 0, 4'h7, 0, 1, 1, 0});
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h7, 0, 1, 1, 0}); // A done
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h7, 0, 1, 1, 0}); // hold
    vq.push_back('{0, 1, 4'h5, 4'hA, 0, 0, 0, 0, 0, 4'h7, 0, 0, 0, 0}); // abort DONE
    vq.push_back('{1, 0, 4'h5, 4'hA, 1, 1, 0, 0, 0, 4'h7, 1, 0, 0, 0}); // INIT
    vq.push_back('{0, 0, 4'h1, 4'h0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'hC, 4'h1, 1, 0, 1, 0, 0, 4'h1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'h6, 4'h3, 1, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0}); // RUN2
    vq.push_back('{0, 1, 4'h6, 4'h3, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0}); // abort RUN
    vq.push_back('{1, 1, 4'h6, 4'h3, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0}); // abort beats start
    vq.push_back('{0, 0, 4'h6, 4'h3, 0, 0, 0, 0, 0, 4'h3, 0, 0, 0, 0});
    vq.push_back('{1, 0, 4'h6, 4'h3, 1, 1, 0, 0, 0, 4'h3, 1, 0, 0, 0}); // START held
    vq.push_back('{1, 0, 4'h1, 4'h0, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0});
    vq.push_back('{1, 0, 4'hC, 4'h1, 1, 0, 1, 0, 0, 4'h1, 0, 0, 0, 0});
    vq.push_back('{1, 0, 4'h6, 4'h3, 1, 0, 1, 0, 0, 4'h3, 0, 0, 0, 0});
    vq.push_back('{1, 0, 4'h3, 4'h7, 1, 0, 1, 0, 0, 4'h7, 0, 1, 1, 0}); // B single DONE
    vq.push_back('{1, 0, 4'hD, 4'hF, 1, 0, 1, 0, 0, 4'h7, 1, 0, 0, 0}); // B INIT
    vq.push_back('{0, 0, 4'hA, 4'hC, 1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0}); // B sig restart
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h1, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h3, 0, 0, 0, 0});
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h7, 0, 1, 1, 0});
    vq.push_back('{0, 0, 4'h5, 4'hA, 0, 0, 0, 1, 1, 4'h7, 0, 1, 1, 0});

    // Reset held with START high: nothing may leave IDLE
    START = 1'b1;
    RN    = 1'b0;
    repeat (3) step();
    chk_idle_a("rst_low", 4'h1, 4'h0);
    chk("rst_low_sigB", sigB, 4'h0);
    START = 1'b0;
    RN    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle_a($sformatf("idle%0d", i), 4'h1, 4'h0);
    end

    for (int i = 0; i < vq.size(); i++) begin
      START = vq[i].st;
      ABORT = vq[i].ab;
      step();
      chk($sformatf("r%0d_patA", i),  patA,  vq[i].pA);
      chk($sformatf("r%0d_sigA", i),  sigA,  vq[i].sA);
      chk($sformatf("r%0d_busyA", i), busyA, vq[i].bA);
      chk($sformatf("r%0d_initA", i), initA, vq[i].iA);
      chk($sformatf("r%0d_enA", i),   enA,   vq[i].eA);
      chk($sformatf("r%0d_doneA", i), doneA, vq[i].dA);
      chk($sformatf("r%0d_passA", i), passA, vq[i].qA);
      chk($sformatf("r%0d_sigB", i),  sigB,  vq[i].sB);
      chk($sformatf("r%0d_initB", i), initB, vq[i].iB);
      chk($sformatf("r%0d_doneB", i), doneB, vq[i].dB);
      chk($sformatf("r%0d_passB", i), passB, vq[i].qB);
      chk($sformatf("r%0d_passC", i), passC, vq[i].qC);
      chk($sformatf("r%0d_doneC", i), doneC, vq[i].dB);
    end
    START = 1'b0;
    ABORT = 1'b0;

    // Async reset between edges in the middle of a run
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (3) step();
    chk("mid_patA", patA, 4'h6);
    chk("mid_sigA", sigA, 4'h3);
    #3 RN = 1'b0;
    #1;
    chk_idle_a("async", 4'h1, 4'h0);
    chk("async_sigB", sigB, 4'h0);
    chk("async_busyB", busyB, 1'b0);
    #1 RN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("postrst%0d_doneA", i), doneA, 1'b0);
      chk($sformatf("postrst%0d_busyA", i), busyA, 1'b0);
    end

    // NPAT=1 with SEED=0 (replaced by 1): INIT, one RUN cycle, DONE
    chk("d_reset_pat", patD, 4'h1);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("d_init", initD, 1'b1);
    chk("d_init_busy", busyD, 1'b1);
    step();
    chk("d_run_en", enD, 1'b1);
    chk("d_run_pat", patD, 4'h1);
    chk("d_run_done", doneD, 1'b0);
    step();
    chk("d_done", doneD, 1'b1);
    chk("d_pass", passD, 1'b1);
    chk("d_done_en", enD, 1'b0);
    chk("d_done_busy", busyD, 1'b0);
    chk("d_done_pat", patD, 4'hC);
    chk("d_done_sig", sigD, 4'h1);
    step();
    chk("d_hold_done", doneD, 1'b1);
    chk("d_hold_sig", sigD, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
